lsu_byte_master: RTL

- Initiator side of the byte-addressed data-memory port.
- Accepts one load or store request at a time from the core's MEM stage and issues one byte access per cycle, little-endian.
- Loads: assembles the read bytes and sign- or zero-extends the result.
- Stores: slices the store word into bytes.
- The core stalls on `req_ready` low until `resp_valid`.

---
 rtl/lsu_byte_master_pkg.sv | 25 ++
 rtl/lsu_byte_master_if.sv | 36 +++
 rtl/lsu_extend.sv | 20 ++
 rtl/lsu_byte_master.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/lsu_byte_master_pkg.sv
// Shared encodings for the byte-serial load/store master.
// Size codes are one-hot; anything else is an illegal request.
package lsu_pkg;

    localparam logic [2:0] SZ_BYTE = 3'b001;
    localparam logic [2:0] SZ_HALF = 3'b010;
    localparam logic [2:0] SZ_WORD = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    // Byte count for a size code; 0 marks an illegal size.
    function automatic logic [2:0] size_to_count(input logic [2:0] size);
        case (size)
            SZ_BYTE: size_to_count = 3'd1;
            SZ_HALF: size_to_count = 3'd2;
            SZ_WORD: size_to_count = 3'd4;
            default: size_to_count = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_master_if.sv
// Core request/response and byte-memory port of the load/store master.
// master = the LSU; slave = the core plus memory it talks to.
interface lsu_byte_master_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        memOffset;
    logic              unsignedFlag;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        input  req_valid, req_write, memOffset, unsignedFlag, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_re, mem_we, mem_wdata
    );

    modport slave (
        output req_valid, req_write, memOffset, unsignedFlag, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_re, mem_we, mem_wdata
    );

endinterface

// File: rtl/lsu_extend.sv
// Sign/zero extension of an assembled load word by access size.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [2:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] ext_o
);

    always_comb begin
        ext_o = data_i;
        case (size_i)
            SZ_BYTE: ext_o = {(unsigned_i ? 24'h0 : {24{data_i[7]}}), data_i[7:0]};
            SZ_HALF: ext_o = {(unsigned_i ? 16'h0 : {16{data_i[15]}}), data_i[15:0]};
            default: ext_o = data_i;
        endcase
    end

endmodule

// File: rtl/lsu_byte_master.sv
// Byte-serial load/store master: one request at a time, one byte per cycle,
// little-endian, with load extension and a one-cycle response pulse.
module lsu_byte_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic clk,
    input  logic rst,
    lsu_byte_master_if.master bus
);

    // state | meaning
    // IDLE  | ready for a request, memory port quiet
    // XFER  | one byte access per cycle, byte k of n
    // RESP  | resp_valid pulse, resp_rdata/resp_err presented

    lsu_state_e        state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [2:0]        n_q, n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              write_q, write_d;
    logic              err_q, err_d;
    logic [31:0]       buf_q, buf_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0]       buf_merged;
    logic [31:0]       ext_w;
    logic              last_byte;
    logic [2:0]        req_count;

    assign last_byte = (({1'b0, k_q} + 3'd1) == n_q);
    assign req_count = size_to_count(bus.memOffset);

    // Load buffer with the byte arriving this cycle already folded in.
    always_comb begin
        buf_merged = buf_q;
        buf_merged[{k_q, 3'b000} +: 8] = bus.mem_rdata;
    end

    lsu_extend u_extend (
        .data_i     (buf_merged),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .ext_o      (ext_w)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        write_d = write_q;
        err_d   = err_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    size_d  = bus.memOffset;
                    uns_d   = bus.unsignedFlag;
                    write_d = bus.req_write;
                    n_d     = req_count;
                    k_d     = 2'd0;
                    buf_d   = 32'h0;
                    if (req_count != 3'd0) begin
                        err_d   = 1'b0;
                        state_d = ST_XFER;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_XFER: begin
                if (!write_q) begin
                    buf_d = buf_merged;
                end
                if (last_byte) begin
                    rdata_d = write_q ? 32'h0 : ext_w;
                    state_d = ST_RESP;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            k_q     <= 2'd0;
            n_q     <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            size_q  <= 3'd0;
            uns_q   <= 1'b0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            buf_q   <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            write_q <= write_d;
            err_q   <= err_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory port is driven only while transferring; quiet (all zero) otherwise.
    always_comb begin
        bus.req_ready  = (state_q == ST_IDLE);
        bus.resp_valid = (state_q == ST_RESP);
        bus.resp_err   = (state_q == ST_RESP) && err_q;
        bus.resp_rdata = rdata_q;
        bus.mem_addr   = '0;
        bus.mem_re     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_wdata  = 8'h0;
        if (state_q == ST_XFER) begin
            bus.mem_addr  = addr_q + {{(ADDR_W-2){1'b0}}, k_q};
            bus.mem_re    = !write_q;
            bus.mem_we    = write_q;
            bus.mem_wdata = write_q ? wdata_q[{k_q, 3'b000} +: 8] : 8'h0;
        end
    end

endmodule
